// File: rtl/pipe_stage_ctrl.sv
// Handshaked pipeline stage: main + skid register with registered ready and flush.
// Optional saturating back-pressure counter enabled by defining PIPE_STAGE_CNT_EN.
module pipe_stage_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [CNT_WIDTH-1:0]  o_stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  xfer_in, xfer_out;
  logic                  load_main_in, load_main_skid, load_skid;

  // Handshake flags depend on state only, so neither ready nor valid
  // combinationally sees the neighbouring stage.
  assign o_valid  = (state_q != EMPTY);
  assign o_ready  = (state_q != FULL);
  assign o_data   = main_q;
  assign xfer_in  = i_valid & o_ready;
  assign xfer_out = o_valid & i_ready;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (i_flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (xfer_in) begin
            state_d      = HALF;
            load_main_in = 1'b1;
          end
        end
        HALF: begin
          if (xfer_in && xfer_out) begin
            load_main_in = 1'b1;
          end else if (xfer_in) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (xfer_out) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // Skid always holds the younger entry; it moves up when main drains.
          if (xfer_out) begin
            state_d        = HALF;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the two data registers are ordinary flops (not a memory array), so
  // clearing them in reset costs nothing and gives a defined o_data.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in) begin
        main_q <= i_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= i_data;
      end
    end
  end

`ifdef PIPE_STAGE_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q;

  // Counts cycles where downstream holds off a valid payload; saturates.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stall_cnt_q <= '0;
    end else if (o_valid && !i_ready && !i_flush && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`else
  assign o_stall_cnt = '0;
`endif

endmodule
